// File: rtl/cavlc_pkg.sv
// Shared constants, state encoding and statistics record for the CAVLC coefficient scanner.
package cavlc_pkg;

    localparam int CAVLC_MAX_COEFFS = 16;
    localparam int CAVLC_MAX_T1     = 3;
    localparam int CAVLC_CNT_W      = $clog2(CAVLC_MAX_COEFFS + 1);
    localparam int CAVLC_T1_W       = $clog2(CAVLC_MAX_T1 + 1);

    typedef enum logic {
        SCAN = 1'b0,
        HOLD = 1'b1
    } scan_state_e;

    typedef struct packed {
        logic [CAVLC_CNT_W-1:0]  total_coeff;
        logic [CAVLC_T1_W-1:0]   trailing_ones;
        logic [CAVLC_MAX_T1-1:0] t1_signs;
        logic [CAVLC_CNT_W-1:0]  total_zeros;
        logic                    len_err;
    } cavlc_stats_t;

endpackage

// File: rtl/cavlc_t1_tracker.sv
// Tracks the run of trailing +/-1 coefficients at the high-frequency end of a block
// and shifts in their sign bits, newest in the LSB.
module cavlc_t1_tracker
    import cavlc_pkg::*;
#(
    parameter int COEFF_W = 8,
    parameter int MAX_T1  = CAVLC_MAX_T1,
    localparam int TW     = $clog2(MAX_T1 + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               beat,
    input  logic [COEFF_W-1:0] coeff,
    output logic [TW-1:0]      trailing_ones,
    output logic [MAX_T1-1:0]  t1_signs
);

    logic              t1_open_reg;
    logic [TW-1:0]     t1_cnt_reg;
    logic [MAX_T1-1:0] t1_signs_reg;
    logic              nz;
    logic              one;

    assign nz  = (coeff != '0);
    // All-ones is -1; the most-negative code can never match either pattern.
    assign one = (coeff == COEFF_W'(1)) || (coeff == {COEFF_W{1'b1}});

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            t1_open_reg  <= 1'b1;
            t1_cnt_reg   <= '0;
            t1_signs_reg <= '0;
        end else if (beat) begin
            if (nz && !one) begin
                t1_open_reg <= 1'b0;
            end else if (t1_open_reg && one && (t1_cnt_reg < TW'(MAX_T1))) begin
                t1_signs_reg <= {t1_signs_reg[MAX_T1-2:0], coeff[COEFF_W-1]};
                t1_cnt_reg   <= t1_cnt_reg + 1'b1;
            end
        end
    end

    assign trailing_ones = t1_cnt_reg;
    assign t1_signs      = t1_signs_reg;

endmodule

// File: rtl/cavlc_coeff_stats_scanner.sv
// Single-pass CAVLC header statistics over a reverse-scan residual block,
// with valid/ready handshakes on the coefficient and statistics sides.
module cavlc_coeff_stats_scanner
    import cavlc_pkg::*;
#(
    parameter int COEFF_W    = 8,
    parameter int MAX_COEFFS = CAVLC_MAX_COEFFS,
    parameter int MAX_T1     = CAVLC_MAX_T1,
    localparam int CW        = $clog2(MAX_COEFFS + 1),
    localparam int TW        = $clog2(MAX_T1 + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COEFF_W-1:0] coeff_i,
    input  logic               coeff_valid,
    input  logic               coeff_last,
    output logic               coeff_ready,
    input  logic [CW-1:0]      max_coeff,
    output logic               stats_valid,
    input  logic               stats_ready,
    output logic [CW-1:0]      total_coeff,
    output logic [TW-1:0]      trailing_ones,
    output logic [MAX_T1-1:0]  t1_signs,
    output logic [CW-1:0]      total_zeros,
    output logic               len_err
);

    scan_state_e   state_reg;
    logic [CW-1:0] beat_cnt_reg;
    logic [CW-1:0] max_len_reg;
    logic [CW-1:0] total_coeff_reg;
    logic [CW-1:0] total_zeros_reg;
    logic          seen_nz_reg;
    logic          len_err_reg;

    logic          accept;
    logic          release_stats;
    logic          first_beat;
    logic          nz;
    logic          at_max;
    logic          end_blk;
    logic [CW-1:0] beat_num;
    logic [CW-1:0] max_len;

    assign accept        = coeff_valid && (state_reg == SCAN);
    assign release_stats = (state_reg == HOLD) && stats_ready;
    assign first_beat    = (beat_cnt_reg == '0);
    // The block length is live on the first beat and latched for the rest.
    assign max_len       = first_beat ? max_coeff : max_len_reg;
    assign beat_num      = beat_cnt_reg + 1'b1;
    assign at_max        = (beat_num == max_len);
    assign end_blk       = coeff_last || at_max;
    assign nz            = (coeff_i != '0);

    always_ff @(posedge clk) begin
        if (rst || release_stats) begin
            state_reg       <= SCAN;
            beat_cnt_reg    <= '0;
            max_len_reg     <= '0;
            total_coeff_reg <= '0;
            total_zeros_reg <= '0;
            seen_nz_reg     <= 1'b0;
            len_err_reg     <= 1'b0;
        end else if (accept) begin
            beat_cnt_reg <= beat_num;
            if (first_beat) begin
                max_len_reg <= max_coeff;
            end
            if (nz) begin
                total_coeff_reg <= total_coeff_reg + 1'b1;
                seen_nz_reg     <= 1'b1;
            end else if (seen_nz_reg) begin
                total_zeros_reg <= total_zeros_reg + 1'b1;
            end
            // Either an early last or a missing last at the length limit is an error.
            if (end_blk) begin
                state_reg   <= HOLD;
                len_err_reg <= !(coeff_last && at_max);
            end
        end
    end

    cavlc_t1_tracker #(
        .COEFF_W (COEFF_W),
        .MAX_T1  (MAX_T1)
    ) u_t1_tracker (
        .clk           (clk),
        .rst           (rst),
        .clear         (release_stats),
        .beat          (accept),
        .coeff         (coeff_i),
        .trailing_ones (trailing_ones),
        .t1_signs      (t1_signs)
    );

    assign coeff_ready = (state_reg == SCAN);
    assign stats_valid = (state_reg == HOLD);
    assign total_coeff = total_coeff_reg;
    assign total_zeros = total_zeros_reg;
    assign len_err     = len_err_reg;

endmodule

// File: tb/tb_cavlc_coeff_stats_scanner.sv
// Bench for the CAVLC statistics scanner: directed blocks with literal expectations,
// then randomized blocks checked every cycle against a behavioural model.
module tb_cavlc_coeff_stats_scanner;
    import cavlc_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] coeff_i;
    logic       coeff_valid;
    logic       coeff_last;
    logic       coeff_ready;
    logic [4:0] max_coeff;
    logic       stats_valid;
    logic       stats_ready;
    logic [4:0] total_coeff;
    logic [1:0] trailing_ones;
    logic [2:0] t1_signs;
    logic [4:0] total_zeros;
    logic       len_err;

    int n_checks = 0;
    int n_fail   = 0;
    int sink_mode = 0;          // 0: hold low, 1: random, 2: always high

    int           blk[$];
    int           blk_max = 0;
    bit           m_hold = 0;
    cavlc_stats_t exp_stats = '0;

    cavlc_coeff_stats_scanner dut (
        .clk           (clk),
        .rst           (rst),
        .coeff_i       (coeff_i),
        .coeff_valid   (coeff_valid),
        .coeff_last    (coeff_last),
        .coeff_ready   (coeff_ready),
        .max_coeff     (max_coeff),
        .stats_valid   (stats_valid),
        .stats_ready   (stats_ready),
        .total_coeff   (total_coeff),
        .trailing_ones (trailing_ones),
        .t1_signs      (t1_signs),
        .total_zeros   (total_zeros),
        .len_err       (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Statistics derived straight from the list of coefficients of one block.
    function automatic cavlc_stats_t model_stats(input int q[$], input int mx, input bit last);
        cavlc_stats_t r;
        int nzv[$];
        int first_nz;
        int tz;
        int ones;
        int signs;
        r = '0;
        first_nz = -1;
        tz = 0;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i] != 0) begin
                nzv.push_back(q[i]);
                if (first_nz < 0) first_nz = i;
            end else if (first_nz >= 0) begin
                tz++;
            end
        end
        ones = 0;
        signs = 0;
        for (int k = 0; k < nzv.size() && k < 3; k++) begin
            if (nzv[k] != 1 && nzv[k] != -1) break;
            signs = signs * 2 + ((nzv[k] < 0) ? 1 : 0);
            ones++;
        end
        r.total_coeff   = CAVLC_CNT_W'(nzv.size());
        r.trailing_ones = CAVLC_T1_W'(ones);
        r.t1_signs      = CAVLC_MAX_T1'(signs);
        r.total_zeros   = CAVLC_CNT_W'(tz);
        r.len_err       = !(last && (q.size() == mx));
        return r;
    endfunction

    // Model: collects accepted beats, closes a block on last or at the length limit.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            blk.delete();
            m_hold = 0;
        end else if (m_hold) begin
            if (stats_ready) m_hold = 0;
        end else if (coeff_valid) begin
            if (blk.size() == 0) blk_max = int'(max_coeff);
            blk.push_back(int'($signed(coeff_i)));
            if (coeff_last || blk.size() == blk_max) begin
                exp_stats = model_stats(blk, blk_max, coeff_last);
                m_hold = 1;
                blk.delete();
            end
        end
    end

    // Compare process: handshake and statistics every cycle out of reset.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            check("stats_valid", int'(stats_valid), int'(m_hold));
            check("coeff_ready", int'(coeff_ready), int'(!m_hold));
            if (m_hold && stats_valid) begin
                check("total_coeff", int'(total_coeff), int'(exp_stats.total_coeff));
                check("trailing_ones", int'(trailing_ones), int'(exp_stats.trailing_ones));
                check("t1_signs", int'(t1_signs), int'(exp_stats.t1_signs));
                check("total_zeros", int'(total_zeros), int'(exp_stats.total_zeros));
                check("len_err", int'(len_err), int'(exp_stats.len_err));
            end
        end
    end

    // Statistics consumer.
    initial begin
        stats_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (sink_mode)
                0:       stats_ready = 1'b0;
                1:       stats_ready = ($urandom_range(0, 2) != 0);
                default: stats_ready = 1'b1;
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send_beat(input int v, input bit last, input int mx);
        bit rdy;
        coeff_i     = 8'(v);
        coeff_last  = last;
        max_coeff   = 5'(mx);
        coeff_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            rdy = coeff_ready;
            @(negedge clk);
            if (rdy) begin
                coeff_valid = 1'b0;
                coeff_last  = 1'b0;
                return;
            end
        end
        coeff_valid = 1'b0;
        coeff_last  = 1'b0;
        timeout_fail("beat_accept");
    endtask

    task automatic send_block(input int vals[16], input int n, input int mx, input bit with_last);
        for (int i = 0; i < n; i++) send_beat(vals[i], with_last && (i == n - 1), mx);
    endtask

    task automatic wait_stats(input string tag);
        int t;
        t = 0;
        while (!stats_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!stats_valid) timeout_fail(tag);
    endtask

    task automatic check_lit(input string tag, input int tc, input int t1, input int sg,
                             input int tz, input int le);
        check($sformatf("%s_total_coeff", tag), int'(total_coeff), tc);
        check($sformatf("%s_trailing_ones", tag), int'(trailing_ones), t1);
        check($sformatf("%s_t1_signs", tag), int'(t1_signs), sg);
        check($sformatf("%s_total_zeros", tag), int'(total_zeros), tz);
        check($sformatf("%s_len_err", tag), int'(len_err), le);
    endtask

    task automatic ack_stats(input string tag);
        int t;
        sink_mode = 2;
        t = 0;
        while (stats_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (stats_valid) timeout_fail(tag);
        sink_mode = 0;
    endtask

    task automatic check_reset(input string tag);
        check($sformatf("%s_coeff_ready", tag), int'(coeff_ready), 1);
        check($sformatf("%s_stats_valid", tag), int'(stats_valid), 0);
        check_lit(tag, 0, 0, 0, 0, 0);
    endtask

    function automatic int rand_coeff();
        case ($urandom_range(0, 7))
            0, 1, 2, 3: return 0;
            4:          return 1;
            5:          return -1;
            6:          return -128;
            default:    return int'($urandom_range(0, 255)) - 128;
        endcase
    endfunction

    int v1[16] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, -1, 0, 0, -1, 3, 0};
    int v2[16] = '{-1, 1, -1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int v0[16] = '{default: 0};
    int v4[16] = '{0, -128, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int v5[16] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int v6[16] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int v7[16] = '{3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int v8[16] = '{0, 1, 0, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    initial begin
        int mx;
        int kind;
        int n;
        int t;
        rst         = 1'b1;
        coeff_i     = '0;
        coeff_valid = 1'b0;
        coeff_last  = 1'b0;
        max_coeff   = 5'd16;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        send_block(v1, 16, 16, 1'b1);
        wait_stats("t1");
        check_lit("t1", 5, 3, 1, 4, 0);
        ack_stats("t1_ack");

        send_block(v2, 16, 16, 1'b1);
        wait_stats("t2");
        check_lit("t2", 5, 3, 5, 11, 0);
        ack_stats("t2_ack");

        send_block(v0, 16, 16, 1'b1);
        check("t3_latency", int'(stats_valid), 1);
        check_lit("t3", 0, 0, 0, 0, 0);
        ack_stats("t3_ack");

        send_block(v4, 4, 4, 1'b1);
        wait_stats("t4");
        check_lit("t4", 2, 0, 0, 1, 0);
        ack_stats("t4_ack");

        send_block(v5, 16, 16, 1'b1);
        wait_stats("t5");
        for (int c = 0; c < 5; c++) begin
            check_lit("t5_hold", 1, 1, 0, 15, 0);
            check("t5_hold_coeff_ready", int'(coeff_ready), 0);
            @(negedge clk);
        end
        ack_stats("t5_ack");
        send_block(v4, 4, 4, 1'b1);
        wait_stats("t5_next");
        check_lit("t5_next", 2, 0, 0, 1, 0);
        ack_stats("t5_next_ack");

        send_block(v6, 12, 15, 1'b1);
        wait_stats("t6a");
        check_lit("t6a", 2, 2, 0, 10, 1);
        ack_stats("t6a_ack");

        send_block(v7, 16, 16, 1'b0);
        wait_stats("t6b");
        check_lit("t6b", 1, 0, 0, 15, 1);
        ack_stats("t6b_ack");
        send_beat(5, 1'b0, 16);
        send_beat(0, 1'b0, 16);
        rst = 1'b1;
        @(negedge clk);
        check_reset("t6_rst");
        rst = 1'b0;
        send_block(v8, 4, 4, 1'b1);
        wait_stats("t6c");
        check_lit("t6c", 2, 2, 1, 1, 0);
        ack_stats("t6c_ack");

        sink_mode = 1;
        for (int b = 0; b < 60; b++) begin
            case ($urandom_range(0, 3))
                0:       mx = 4;
                1:       mx = 8;
                2:       mx = 15;
                default: mx = 16;
            endcase
            kind = int'($urandom_range(0, 9));
            if (kind == 0)      n = int'($urandom_range(1, mx - 1));
            else if (kind == 1) n = mx + int'($urandom_range(1, 3));
            else                n = mx;
            for (int i = 0; i < n; i++) begin
                send_beat(rand_coeff(), (kind != 1) && (i == n - 1), mx);
                if ($urandom_range(0, 3) == 0) @(negedge clk);
            end
        end
        send_beat(0, 1'b1, 16);

        t = 0;
        while ((stats_valid || m_hold) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (stats_valid || m_hold) timeout_fail("drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
